// File: rtl/life_pkg.sv
// Shared types and helpers for the Game-of-Life engine.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } life_state_t;

    localparam int NBR_W = 4;

    // Cell (r,c) lives at bit r*cols+c of the flattened grid vector.
    function automatic int idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/life_next_gen.sv
// Combinational Game-of-Life successor: one neighbour counter per cell.
module life_next_gen
    import life_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int WRAP = 0
) (
    input  logic [ROWS*COLS-1:0] grid,
    output logic [ROWS*COLS-1:0] next_grid
);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [8:0]       nb;
            logic [NBR_W-1:0] n;

            // Neighbour k covers offset (k/3-1, k%3-1); k==4 is the cell itself.
            for (genvar k = 0; k < 9; k++) begin : g_nb
                localparam int  RR     = r + k / 3 - 1;
                localparam int  CC     = c + k % 3 - 1;
                localparam bit  INSIDE = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
                localparam int  RW     = (RR + ROWS) % ROWS;
                localparam int  CW     = (CC + COLS) % COLS;
                if (k == 4) begin : g_self
                    assign nb[k] = 1'b0;
                end else if (WRAP != 0 || INSIDE) begin : g_live
                    assign nb[k] = grid[idx(RW, CW, COLS)];
                end else begin : g_dead
                    assign nb[k] = 1'b0;
                end
            end

            assign n = NBR_W'($countones(nb));
            assign next_grid[idx(r, c, COLS)] = (n == NBR_W'(3)) |
                                                (grid[idx(r, c, COLS)] & (n == NBR_W'(2)));
        end
    end

endmodule

// File: rtl/life_engine_param.sv
// Game-of-Life engine: grid register, run/pause/step FSM, generation counter, stable/extinct flags.
module life_engine_param
    import life_pkg::*;
#(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int WRAP      = 0,
    parameter int AUTO_HALT = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] seed,
    input  logic                 run,
    input  logic                 step,
    output logic [ROWS*COLS-1:0] grid,
    output logic [CNT_W-1:0]     gen_count,
    output logic                 stable,
    output logic                 extinct,
    output logic                 halted,
    output life_state_t          dbg_state
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ROWS*COLS-1:0] next_grid;
    logic                 next_same;
    logic                 next_zero;
    life_state_t          state;

    life_next_gen #(.ROWS(ROWS), .COLS(COLS), .WRAP(WRAP)) u_next (
        .grid      (grid),
        .next_grid (next_grid)
    );

    assign next_same = (next_grid == grid);
    assign next_zero = (next_grid == '0);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grid      <= '0;
            gen_count <= '0;
            stable    <= 1'b0;
            extinct   <= 1'b1;
            halted    <= 1'b0;
            state     <= IDLE;
        end else if (load) begin
            grid      <= seed;
            gen_count <= '0;
            stable    <= 1'b0;
            extinct   <= (seed == '0);
            halted    <= 1'b0;
            state     <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= RUN;
                    end else if (step) begin
                        grid      <= next_grid;
                        gen_count <= (gen_count == CNT_MAX) ? gen_count : gen_count + 1'b1;
                        stable    <= next_same;
                        extinct   <= next_zero;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state <= IDLE;
                    end else begin
                        grid      <= next_grid;
                        gen_count <= (gen_count == CNT_MAX) ? gen_count : gen_count + 1'b1;
                        stable    <= next_same;
                        extinct   <= next_zero;
                        // The halting generation is still committed, then the grid freezes.
                        if (AUTO_HALT != 0 && (next_same || next_zero)) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_engine_param.sv
// Bench for life_engine_param: three 8x8 instances (dead edge, toroidal, 4-bit counter) against a cell-rule model.
module tb_life_engine_param;
    import life_pkg::*;

    logic        clk;
    logic        reset;
    logic        load;
    logic [63:0] seed;
    logic        run;
    logic        step;

    logic [63:0] grid_o   [3];
    logic [15:0] gen_o    [3];
    logic [3:0]  gen2_raw;
    logic        stable_o [3];
    logic        extinct_o[3];
    logic        halted_o [3];
    life_state_t st_o     [3];

    assign gen_o[2] = {12'd0, gen2_raw};

    // Model state per instance: mode 0 = paused, 1 = running, 2 = halted.
    logic [63:0] m_grid   [3];
    int          m_gen    [3];
    bit          m_stable [3];
    bit          m_extinct[3];
    int          m_mode   [3];
    bit          m_wrap   [3];
    int          m_max    [3];

    int checks;
    int errors;

    life_engine_param #(.ROWS(8), .COLS(8), .WRAP(0), .AUTO_HALT(1), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run), .step(step),
        .grid(grid_o[0]), .gen_count(gen_o[0]), .stable(stable_o[0]), .extinct(extinct_o[0]),
        .halted(halted_o[0]), .dbg_state(st_o[0]));

    life_engine_param #(.ROWS(8), .COLS(8), .WRAP(1), .AUTO_HALT(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run), .step(step),
        .grid(grid_o[1]), .gen_count(gen_o[1]), .stable(stable_o[1]), .extinct(extinct_o[1]),
        .halted(halted_o[1]), .dbg_state(st_o[1]));

    life_engine_param #(.ROWS(8), .COLS(8), .WRAP(0), .AUTO_HALT(1), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run), .step(step),
        .grid(grid_o[2]), .gen_count(gen2_raw), .stable(stable_o[2]), .extinct(extinct_o[2]),
        .halted(halted_o[2]), .dbg_state(st_o[2]));

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] model_next(input logic [63:0] g, input bit wrap);
        logic [63:0] res;
        int n, rr, cc;
        res = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
                            if (wrap) begin
                                rr = (rr + 8) % 8;
                                cc = (cc + 8) % 8;
                                n += int'(g[rr*8+cc]);
                            end else if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
                                n += int'(g[rr*8+cc]);
                            end
                        end
                    end
                end
                res[r*8+c] = (n == 3) || (g[r*8+c] && n == 2);
            end
        end
        return res;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_grid[i] = '0; m_gen[i] = 0; m_stable[i] = 0; m_extinct[i] = 1; m_mode[i] = 0;
        end
    endtask

    task automatic model_advance(input int i);
        logic [63:0] nx;
        nx = model_next(m_grid[i], m_wrap[i]);
        m_stable[i]  = (nx == m_grid[i]);
        m_extinct[i] = (nx == 64'd0);
        if (m_mode[i] == 1 && (m_stable[i] || m_extinct[i])) m_mode[i] = 2;
        m_grid[i] = nx;
        if (m_gen[i] < m_max[i]) m_gen[i]++;
    endtask

    task automatic model_tick();
        for (int i = 0; i < 3; i++) begin
            if (load) begin
                m_grid[i] = seed; m_gen[i] = 0; m_stable[i] = 0;
                m_extinct[i] = (seed == 64'd0); m_mode[i] = 0;
            end else if (m_mode[i] == 0) begin
                if (run) m_mode[i] = 1;
                else if (step) model_advance(i);
            end else if (m_mode[i] == 1) begin
                if (!run) m_mode[i] = 0;
                else model_advance(i);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit l, input logic [63:0] s, input bit r, input bit st);
        load = l; seed = s; run = r; step = st;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(0, 64'd0, 0, 0);
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (grid_o[i] !== 64'd0 || gen_o[i] !== 16'd0 || stable_o[i] !== 1'b0 ||
                extinct_o[i] !== 1'b1 || halted_o[i] !== 1'b0 || st_o[i] !== IDLE) begin
                errors++;
                $display("FAIL reset[%0d] grid=%h gen=%0d st=%b ex=%b h=%b state=%0d exp grid=0 gen=0 st=0 ex=1 h=0 IDLE",
                         i, grid_o[i], gen_o[i], stable_o[i], extinct_o[i], halted_o[i], st_o[i]);
            end
        end
        reset = 1'b1;
        #2;
    endtask

    task automatic test_blinker_step();
        drive(1, 64'h0000_0000_1C00_0000, 0, 0);
        cycle();
        drive(0, 64'd0, 0, 1);
        cycle();
        checks++;
        if (grid_o[0] !== 64'h0000_0008_0808_0000) begin
            errors++;
            $display("FAIL blinker_step1 grid=%h exp=%h", grid_o[0], 64'h0000_0008_0808_0000);
        end
        cycle();
        step = 0;
        checks++;
        if (grid_o[0] !== 64'h0000_0000_1C00_0000 || gen_o[0] !== 16'd2 || stable_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL blinker_step2 grid=%h gen=%0d stable=%b exp grid=%h gen=2 stable=0",
                     grid_o[0], gen_o[0], stable_o[0], 64'h0000_0000_1C00_0000);
        end
        cycle();
        checks++;
        if (gen_o[0] !== 16'd2 || st_o[0] !== IDLE) begin
            errors++;
            $display("FAIL blinker_pause gen=%0d state=%0d exp gen=2 IDLE", gen_o[0], st_o[0]);
        end
    endtask

    task automatic test_block_halt();
        drive(1, 64'h0000_0000_0000_0303, 0, 0);
        cycle();
        drive(0, 64'd0, 1, 0);
        cycle();
        checks++;
        if (gen_o[0] !== 16'd0 || st_o[0] !== RUN) begin
            errors++;
            $display("FAIL block_enter_run gen=%0d state=%0d exp gen=0 RUN", gen_o[0], st_o[0]);
        end
        cycle();
        checks++;
        if (stable_o[0] !== 1'b1 || halted_o[0] !== 1'b1 || grid_o[0] !== 64'h0303 || gen_o[0] !== 16'd1) begin
            errors++;
            $display("FAIL block_halt stable=%b halted=%b grid=%h gen=%0d exp 1 1 %h 1",
                     stable_o[0], halted_o[0], grid_o[0], gen_o[0], 64'h0303);
        end
        drive(0, 64'd0, 0, 1);
        repeat (3) cycle();
        drive(0, 64'd0, 1, 0);
        cycle();
        checks++;
        if (halted_o[0] !== 1'b1 || gen_o[0] !== 16'd1 || grid_o[0] !== 64'h0303) begin
            errors++;
            $display("FAIL halt_frozen halted=%b gen=%0d grid=%h exp 1 1 %h",
                     halted_o[0], gen_o[0], grid_o[0], 64'h0303);
        end
    endtask

    task automatic test_single_cell();
        drive(1, 64'h1, 0, 0);
        cycle();
        checks++;
        if (extinct_o[0] !== 1'b0 || grid_o[0] !== 64'h1) begin
            errors++;
            $display("FAIL single_load extinct=%b grid=%h exp 0 %h", extinct_o[0], grid_o[0], 64'h1);
        end
        drive(0, 64'd0, 1, 0);
        repeat (2) cycle();
        checks++;
        if (grid_o[0] !== 64'd0 || extinct_o[0] !== 1'b1 || halted_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_extinct grid=%h extinct=%b halted=%b exp 0 1 1",
                     grid_o[0], extinct_o[0], halted_o[0]);
        end
    endtask

    task automatic test_glider();
        drive(1, 64'h0000_0000_0007_0402, 0, 0);
        cycle();
        drive(0, 64'd0, 1, 0);
        repeat (33) cycle();
        checks++;
        if (grid_o[1] !== 64'h0000_0000_0007_0402 || gen_o[1] !== 16'd32 || halted_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL glider_wrap grid=%h gen=%0d halted=%b exp %h 32 0",
                     grid_o[1], gen_o[1], halted_o[1], 64'h0000_0000_0007_0402);
        end
        repeat (30) cycle();
        checks++;
        if (grid_o[0] !== m_grid[0] || stable_o[0] !== 1'b1 || halted_o[0] !== 1'b1 ||
            $countones(grid_o[0]) != 4) begin
            errors++;
            $display("FAIL glider_dead grid=%h stable=%b halted=%b exp grid=%h (block) stable=1 halted=1",
                     grid_o[0], stable_o[0], halted_o[0], m_grid[0]);
        end
        run = 0;
    endtask

    task automatic test_counter_saturate();
        drive(1, 64'h0000_0000_1C00_0000, 0, 0);
        cycle();
        drive(0, 64'd0, 1, 0);
        repeat (20) cycle();
        checks++;
        if (gen_o[2] !== 16'd15 || grid_o[2] !== m_grid[2] || halted_o[2] !== 1'b0) begin
            errors++;
            $display("FAIL cnt_saturate gen=%0d grid=%h halted=%b exp 15 %h 0",
                     gen_o[2], grid_o[2], halted_o[2], m_grid[2]);
        end
        drive(1, 64'h0000_0000_1C00_0000, 1, 1);
        cycle();
        checks++;
        if (gen_o[2] !== 16'd0 || st_o[2] !== IDLE || grid_o[2] !== 64'h0000_0000_1C00_0000) begin
            errors++;
            $display("FAIL load_mid_run gen=%0d state=%0d grid=%h exp 0 IDLE %h",
                     gen_o[2], st_o[2], grid_o[2], 64'h0000_0000_1C00_0000);
        end
        drive(0, 64'd0, 0, 0);
        cycle();
    endtask

    task automatic test_reset_mid_run();
        drive(1, 64'h0000_0000_1C00_0000, 0, 0);
        cycle();
        drive(0, 64'd0, 1, 0);
        repeat (5) cycle();
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (grid_o[0] !== 64'd0 || gen_o[0] !== 16'd0 || extinct_o[0] !== 1'b1 ||
            stable_o[0] !== 1'b0 || halted_o[0] !== 1'b0 || st_o[0] !== IDLE) begin
            errors++;
            $display("FAIL reset_async grid=%h gen=%0d ex=%b st=%b h=%b state=%0d exp cleared",
                     grid_o[0], gen_o[0], extinct_o[0], stable_o[0], halted_o[0], st_o[0]);
        end
        @(posedge clk);
        #1;
        drive(0, 64'd0, 0, 0);
        reset = 1'b1;
        cycle();
        checks++;
        if (st_o[0] !== IDLE || grid_o[0] !== 64'd0 || gen_o[0] !== 16'd0) begin
            errors++;
            $display("FAIL reset_release state=%0d grid=%h gen=%0d exp IDLE 0 0",
                     st_o[0], grid_o[0], gen_o[0]);
        end
    endtask

    task automatic test_random();
        logic [63:0] s;
        for (int n = 0; n < 300; n++) begin
            s = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) s = s & {$urandom, $urandom};
            load = ($urandom_range(0, 11) == 0);
            seed = s;
            if ($urandom_range(0, 5) == 0) run = ~run;
            step = ($urandom_range(0, 2) == 0);
            cycle();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (grid_o[i] !== m_grid[i] || gen_o[i] !== 16'(m_gen[i]) ||
                    stable_o[i] !== m_stable[i] || extinct_o[i] !== m_extinct[i] ||
                    halted_o[i] !== (m_mode[i] == 2)) begin
                    errors++;
                    $display("FAIL random[%0d] cyc=%0d grid=%h gen=%0d st=%b ex=%b h=%b exp grid=%h gen=%0d st=%b ex=%b h=%b",
                             i, n, grid_o[i], gen_o[i], stable_o[i], extinct_o[i], halted_o[i],
                             m_grid[i], m_gen[i], m_stable[i], m_extinct[i], (m_mode[i] == 2));
                end
            end
        end
        drive(0, 64'd0, 0, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_wrap[0] = 0; m_wrap[1] = 1; m_wrap[2] = 0;
        m_max[0] = 65535; m_max[1] = 65535; m_max[2] = 15;
        test_reset();
        test_blinker_step();
        test_block_halt();
        test_single_cell();
        test_glider();
        test_counter_saturate();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
